systolic_feeder: RTL

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_feeder
// Description : Skews input vectors into a diagonal wavefront for the edge of
//               a systolic PE array. Lane i is delayed by i advances, so the
//               PE at row/column i sees element i one beat after lane i-1.
//               A FEED phase accepts k_len vectors. A FLUSH phase then pushes
//               zeros for LANES-1 beats to drain the skew.
//               Optional build macro SYSTOLIC_FEEDER_STALL_CNT_EN adds a
//               16-bit saturating count of FEED stall cycles (stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_feeder #(
  parameter int BITWIDTH = 8,
  parameter int LANES    = 4,
  parameter int KW       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [KW-1:0]             k_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BITWIDTH*LANES-1:0] in_vec,
  output logic [BITWIDTH*LANES-1:0] out_vec,
  output logic                      pe_en,
  output logic                      busy,
  output logic                      done
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  // --------------------------------------------------------------------------
  // State encoding and flush counter sizing
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FEED  = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  // The flush counter only has to reach LANES-2 (the last flush beat).
  localparam int c_FW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int c_FLUSH_LAST_I = (LANES > 1) ? (LANES - 2) : 0;
  localparam logic [c_FW-1:0] c_FLUSH_LAST = c_FW'(c_FLUSH_LAST_I);

  logic [1:0]      state_q, state_d;
  logic [KW-1:0]   klen_q, klen_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic [c_FW-1:0] flush_q, flush_d;
  logic            pe_en_q;

  logic [KW-1:0]   w_beat_inc;
  logic            w_start_acc;
  logic            w_accept;
  logic            w_adv;

  wire  [BITWIDTH*LANES-1:0] w_out_vec;

  assign w_beat_inc  = beat_q + KW'(1);
  assign w_start_acc = (state_q == c_IDLE) && start;
  assign w_accept    = (state_q == c_FEED) && in_valid;
  // The array advances on every accepted vector and on every flush beat.
  assign w_adv       = w_accept || (state_q == c_FLUSH);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------

  // State register together with the job length, beat and flush counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
    end
  end

  // Next-state logic: job setup, vector counting and flush length.
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    case (state_q)
      c_IDLE: begin
        if (start) begin
          klen_d  = k_len;
          beat_d  = '0;
          flush_d = '0;
          state_d = (k_len == '0) ? c_DONE : c_FEED;
        end
      end
      c_FEED: begin
        if (in_valid) begin
          beat_d = w_beat_inc;
          // A single lane has no skew to drain, so it skips FLUSH.
          if (w_beat_inc == klen_q) begin
            state_d = (LANES == 1) ? c_DONE : c_FLUSH;
          end
        end
      end
      c_FLUSH: begin
        flush_d = flush_q + c_FW'(1);
        if (flush_q == c_FLUSH_LAST) begin
          state_d = c_DONE;
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    in_ready = (state_q == c_FEED);
    busy     = (state_q != c_IDLE);
    done     = (state_q == c_DONE);
  end

  // --------------------------------------------------------------------------
  // PE enable: one cycle behind each advance, aligned with out_vec updates
  // --------------------------------------------------------------------------

  // Register the advance strobe so it coincides with the new out_vec value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_en_q <= 1'b0;
    end else begin
      pe_en_q <= w_adv;
    end
  end

  assign pe_en = pe_en_q;

  // --------------------------------------------------------------------------
  // Skew lanes: lane i = i-stage delay line followed by an output register
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [BITWIDTH-1:0] w_lane_in;
      logic [BITWIDTH-1:0] lane_out_q;

      // Zeros are injected outside FEED so that FLUSH drains clean data.
      assign w_lane_in = (state_q == c_FEED) ?
                         in_vec[gi*BITWIDTH +: BITWIDTH] : '0;

      if (gi == 0) begin : g_direct
        // Lane 0 has no delay: the output register takes the input directly.
        always_ff @(posedge clk) begin
          if (rst || w_start_acc) begin
            lane_out_q <= '0;
          end else if (w_adv) begin
            lane_out_q <= w_lane_in;
          end
        end
      end else begin : g_delay
        logic [BITWIDTH-1:0] stage_q [gi];

        // Shift the delay line and output register together on each advance.
        always_ff @(posedge clk) begin
          if (rst || w_start_acc) begin
            for (int j = 0; j < gi; j++) begin
              stage_q[j] <= '0;
            end
            lane_out_q <= '0;
          end else if (w_adv) begin
            stage_q[0] <= w_lane_in;
            for (int j = 1; j < gi; j++) begin
              stage_q[j] <= stage_q[j-1];
            end
            lane_out_q <= stage_q[gi-1];
          end
        end
      end

      assign w_out_vec[gi*BITWIDTH +: BITWIDTH] = lane_out_q;
    end
  endgenerate

  assign out_vec = w_out_vec;

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  // --------------------------------------------------------------------------
  // Stall counter: FEED cycles without valid input, saturating
  // --------------------------------------------------------------------------
  logic [15:0] stall_cnt_q;

  // Count FEED stalls since the last accepted start, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      stall_cnt_q <= '0;
    end else if ((state_q == c_FEED) && !in_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire
